mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Arbitrates the single shared main memory (memory4c, pipelined, fixed read latency, data_valid strobe) between I-cache miss fills, D-cache miss fills and D-cache write-through stores. It sits directly downstream of both caches and directly upstream of main memory. It sequences 8-word block fills and returns each word to the requesting cache with data and tag write-enables. It replaces per-cache fill FSMs and the miss-address mux in the memory system.

Parameters:
AWIDTH, 16, byte address width
DWIDTH, 16, data word width
WORDS, 8, words per cache block (block = 16 bytes, word address step 2)
CNTW, 4, width of issue/return counters (must hold 0..WORDS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
icache_miss  in  1  I-cache miss request, level, held until its tag write
icache_miss_addr  in  AWIDTH  I-cache miss byte address
dcache_miss  in  1  D-cache miss request, level, held until its tag write
dcache_miss_addr  in  AWIDTH  D-cache miss byte address
dcache_wr  in  1  store write-through request, level, held until wr_done
dcache_wr_addr  in  AWIDTH  store address
dcache_wr_data  in  DWIDTH  store data
mem_data_out  in  DWIDTH  memory read data
mem_data_valid  in  1  memory read data valid
mem_addr  out  AWIDTH  memory address
mem_data_in  out  DWIDTH  memory write data
mem_enable  out  1  memory enable
mem_wr  out  1  memory write strobe
fill_addr  out  AWIDTH  address of the word being written into a cache
fill_data  out  DWIDTH  word being written into a cache (mem_data_out passthrough)
icache_data_wen  out  1  I-cache data-array write enable
icache_tag_wen  out  1  I-cache tag-array write enable
dcache_data_wen  out  1  D-cache data-array write enable
dcache_tag_wen  out  1  D-cache tag-array write enable
icache_busy  out  1  I-cache fill in progress
dcache_busy  out  1  D-cache fill in progress
wr_done  out  1  one-cycle store-complete pulse

Behaviour:
- States: IDLE, FILL_I, FILL_D, WRITE. On rst low: state IDLE, counters 0, base address 0, i_prio 0. All outputs 0 while in reset and in IDLE.
- IDLE arbitration, evaluated each cycle:
  - If i_prio=1 and icache_miss=1, grant I.
  - Otherwise priority is dcache_miss, then dcache_wr, then icache_miss.
  - Grant registers the base address (miss_addr with bits [3:0] cleared) and moves to FILL_x or WRITE on the next edge.
- i_prio is set on any D fill or store grant made while icache_miss=1. It is cleared on an I grant. This guarantees an I fill is never starved by more than one D transaction.
- FILL_x issue:
  - While issue_cnt < WORDS: mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_cnt; issue_cnt increments every cycle.
  - Once issue_cnt = WORDS: mem_enable=0.
- FILL_x return:
  - Each cycle with mem_data_valid=1 and ret_cnt < WORDS: fill_addr = base + 2*ret_cnt, fill_data = mem_data_out, the requester's data_wen=1, and ret_cnt increments.
  - On the return with ret_cnt = WORDS-1, the requester's tag_wen=1 in the same cycle as its last data_wen.
  - The next state is IDLE and both counters clear.
- Completion depends on ret_cnt only, not on a fixed latency. mem_data_valid outside FILL_x, or beyond WORDS returns, is ignored.
- icache_busy / dcache_busy are high for every cycle in FILL_I / FILL_D, including the tag_wen cycle.
- WRITE lasts exactly one cycle: mem_enable=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_data_in=dcache_wr_data, wr_done=1. The next state is IDLE.
- Simultaneous dcache_miss and dcache_wr: the fill goes first, then the store on a later IDLE arbitration. Writes are never issued while a fill is outstanding.
- A request dropping mid-fill is ignored; the fill runs to 8 words. A request changing address mid-fill is ignored; the latched base is used.
- Address arithmetic is modulo 2^AWIDTH. Block 0xFFF0 issues 0xFFF0..0xFFFE with no carry into the next block.
- Reset asserted mid-fill aborts immediately with no tag_wen. In-flight memory returns after release are ignored, because the state is IDLE.
- Latency with memory latency 4 and a request seen in IDLE at cycle 0:
  - Addresses issued on cycles 1..8.
  - Data_wen on cycles 5..12.
  - Tag_wen on cycle 12.
  - IDLE on cycle 13, with the next grant possible in that same cycle.

Test Plan:
- Reset: rst low for 3 cycles with all requests high -> all outputs 0; after release, the first grant occurs on the first IDLE cycle.
- D fill: dcache_miss=1, addr 0x1236 at cycle 0, memory latency 4, returns 0xA000+k -> mem_addr 0x1230..0x123E on cycles 1..8; dcache_data_wen on 5..12 with fill_addr 0x1230+2k and fill_data 0xA000+k; dcache_tag_wen only on cycle 12; dcache_busy on 1..12.
- Store: dcache_wr=1, addr 0x0040, data 0xBEEF in IDLE -> next cycle mem_wr=1, mem_enable=1, mem_addr 0x0040, mem_data_in 0xBEEF, wr_done=1 for exactly one cycle.
- Contention and fairness: icache_miss 0x0100 and dcache_miss 0x2000 rise together, dcache_miss re-asserted with 0x3000 after its tag write -> D fill 0x2000, then I fill 0x0100, then D fill 0x3000.
- Wrap and odd latency: dcache_miss 0xFFF8, memory latency 6 with a 2-cycle valid gap after word 3 -> addresses 0xFFF0..0xFFFE; exactly 8 data_wen; tag_wen on the 8th valid return; stray valid in IDLE produces no wen.
- Reset mid-fill: assert rst after the 3rd data_wen of an I fill -> no tag_wen; busy drops immediately; a re-issued icache_miss after release performs a full 8-word fill.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: sequences I-cache and D-cache 8-word block fills and
// D-cache write-through stores onto a single pipelined memory with a data_valid strobe.
module mem_arbiter #(
  parameter int unsigned AWIDTH = 16,
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned WORDS  = 8,
  parameter int unsigned CNTW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [AWIDTH-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [AWIDTH-1:0] dcache_miss_addr,
  input  logic              dcache_wr,
  input  logic [AWIDTH-1:0] dcache_wr_addr,
  input  logic [DWIDTH-1:0] dcache_wr_data,
  input  logic [DWIDTH-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data_in,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] fill_addr,
  output logic [DWIDTH-1:0] fill_data,
  output logic              icache_data_wen,
  output logic              icache_tag_wen,
  output logic              dcache_data_wen,
  output logic              dcache_tag_wen,
  output logic              icache_busy,
  output logic              dcache_busy,
  output logic              wr_done
);

  localparam logic [CNTW-1:0]   NumWords  = CNTW'(WORDS);
  localparam logic [CNTW-1:0]   LastWord  = CNTW'(WORDS - 1);
  localparam logic [AWIDTH-1:0] BlockMask = ~AWIDTH'(2 * WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFillI, StFillD, StWrite} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNTW-1:0]   ret_cnt_q, ret_cnt_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic              i_prio_q, i_prio_d;
  logic              take_ret;

  // Word index to byte offset; block offsets never exceed the cleared low bits.
  function automatic logic [AWIDTH-1:0] word_off(input logic [CNTW-1:0] n);
    return AWIDTH'({n, 1'b0});
  endfunction

  always_comb begin
    state_d         = state_q;
    issue_cnt_d     = issue_cnt_q;
    ret_cnt_d       = ret_cnt_q;
    base_d          = base_q;
    i_prio_d        = i_prio_q;
    take_ret        = 1'b0;
    mem_addr        = '0;
    mem_data_in     = '0;
    mem_enable      = 1'b0;
    mem_wr          = 1'b0;
    fill_addr       = '0;
    fill_data       = '0;
    icache_data_wen = 1'b0;
    icache_tag_wen  = 1'b0;
    dcache_data_wen = 1'b0;
    dcache_tag_wen  = 1'b0;
    icache_busy     = (state_q == StFillI);
    dcache_busy     = (state_q == StFillD);
    wr_done         = 1'b0;

    unique case (state_q)
      StIdle: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        // A pending I miss that already lost once wins outright.
        if (i_prio_q && icache_miss) begin
          state_d  = StFillI;
          base_d   = icache_miss_addr & BlockMask;
          i_prio_d = 1'b0;
        end else if (dcache_miss) begin
          state_d  = StFillD;
          base_d   = dcache_miss_addr & BlockMask;
          i_prio_d = i_prio_q | icache_miss;
        end else if (dcache_wr) begin
          state_d  = StWrite;
          i_prio_d = i_prio_q | icache_miss;
        end else if (icache_miss) begin
          state_d  = StFillI;
          base_d   = icache_miss_addr & BlockMask;
          i_prio_d = 1'b0;
        end
      end

      StFillI, StFillD: begin
        if (issue_cnt_q < NumWords) begin
          mem_enable  = 1'b1;
          mem_addr    = base_q + word_off(issue_cnt_q);
          issue_cnt_d = issue_cnt_q + CNTW'(1);
        end
        take_ret = mem_data_valid && (ret_cnt_q < NumWords);
        if (take_ret) begin
          fill_addr       = base_q + word_off(ret_cnt_q);
          fill_data       = mem_data_out;
          icache_data_wen = (state_q == StFillI);
          dcache_data_wen = (state_q == StFillD);
          ret_cnt_d       = ret_cnt_q + CNTW'(1);
          if (ret_cnt_q == LastWord) begin
            icache_tag_wen = (state_q == StFillI);
            dcache_tag_wen = (state_q == StFillD);
            state_d        = StIdle;
            issue_cnt_d    = '0;
            ret_cnt_d      = '0;
          end
        end
      end

      StWrite: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = dcache_wr_addr;
        mem_data_in = dcache_wr_data;
        wr_done     = 1'b1;
        state_d     = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      base_q      <= '0;
      i_prio_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      base_q      <= base_d;
      i_prio_q    <= i_prio_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model and a pipelined memory model with gaps.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        icache_miss, dcache_miss, dcache_wr;
  logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic [15:0] mem_addr, mem_data_in, fill_addr, fill_data;
  logic        mem_enable, mem_wr;
  logic        icache_data_wen, icache_tag_wen, dcache_data_wen, dcache_tag_wen;
  logic        icache_busy, dcache_busy, wr_done;

  mem_arbiter #(.AWIDTH(16), .DWIDTH(16), .WORDS(8), .CNTW(4)) dut (
    .clk(clk), .rst(rst),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .icache_data_wen(icache_data_wen), .icache_tag_wen(icache_tag_wen),
    .dcache_data_wen(dcache_data_wen), .dcache_tag_wen(dcache_tag_wen),
    .icache_busy(icache_busy), .dcache_busy(dcache_busy), .wr_done(wr_done)
  );

  int n_checks = 0, n_pass = 0, cyc = 0;

  // Requester intent; copied onto the DUT pins just after each falling edge.
  logic        rst_req = 1'b0, i_req = 1'b0, d_req = 1'b0, w_req = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, w_addr = '0, w_data = '0;
  bit          auto_req = 0, rearm_d = 0, stray_en = 0, rand_gap = 0;

  // Memory model: fixed latency pipeline of pending reads.
  logic [15:0] mem_arr [32768];
  int          q_due[$];
  logic [15:0] q_data[$];
  int          lat = 4, gap_at = -1, gap_left = 0, mem_rets = 0;
  bit          from_q;

  // Reference model: current transaction (0 none, 1 I fill, 2 D fill, 3 store).
  int          m_kind = 0, m_cyc = 0, m_ret = 0;
  logic [15:0] m_base = '0;
  bit          m_owed_i = 0;

  int          cnt_iwen, cnt_itag, cnt_dwen, cnt_dtag, cnt_dbusy, cnt_wd, first_dwen, last_dtag;
  int          log_kind[$];
  logic [15:0] log_addr[$];
  logic        prev_ib = 1'b0, prev_db = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic clear_counts();
    cnt_iwen = 0; cnt_itag = 0; cnt_dwen = 0; cnt_dtag = 0; cnt_dbusy = 0; cnt_wd = 0;
    first_dwen = -1; last_dtag = -1;
    log_kind.delete(); log_addr.delete();
  endtask

  task automatic step();
    logic [15:0] e_maddr, e_mdin, e_faddr, e_fdata;
    logic        e_en, e_wr, e_idw, e_itw, e_ddw, e_dtw, e_ib, e_db, e_wd;
    int          g;
    @(negedge clk);
    rst = rst_req;
    icache_miss = i_req;  icache_miss_addr = i_addr;
    dcache_miss = d_req;  dcache_miss_addr = d_addr;
    dcache_wr = w_req;    dcache_wr_addr = w_addr;  dcache_wr_data = w_data;
    mem_data_valid = 1'b0; mem_data_out = '0; from_q = 0;
    if (gap_left > 0) gap_left--;
    else if (rst_req && q_due.size() > 0 && q_due[0] <= cyc) begin
      mem_data_valid = 1'b1; mem_data_out = q_data[0]; from_q = 1;
    end else if (stray_en && rst_req && m_kind == 0 && q_due.size() == 0 &&
                 $urandom_range(0, 2) == 0) begin
      mem_data_valid = 1'b1; mem_data_out = 16'($urandom);
    end
    #1;

    {e_en, e_wr, e_idw, e_itw, e_ddw, e_dtw, e_ib, e_db, e_wd} = '0;
    e_maddr = '0; e_mdin = '0; e_faddr = '0; e_fdata = '0; g = 0;
    if (rst) begin
      if (m_kind == 0) begin
        if (m_owed_i && icache_miss) g = 1;
        else if (dcache_miss) g = 2;
        else if (dcache_wr) g = 3;
        else if (icache_miss) g = 1;
      end else if (m_kind == 3) begin
        e_en = 1; e_wr = 1; e_maddr = dcache_wr_addr; e_mdin = dcache_wr_data; e_wd = 1;
      end else begin
        e_ib = (m_kind == 1); e_db = (m_kind == 2);
        if (m_cyc < 8) begin e_en = 1; e_maddr = m_base + 16'(2 * m_cyc); end
        if (mem_data_valid && m_ret < 8) begin
          e_faddr = m_base + 16'(2 * m_ret); e_fdata = mem_data_out;
          e_idw = (m_kind == 1); e_ddw = (m_kind == 2);
          e_itw = e_idw && (m_ret == 7); e_dtw = e_ddw && (m_ret == 7);
        end
      end
    end
    check("mem", {mem_enable, mem_wr, mem_addr, mem_data_in}, {e_en, e_wr, e_maddr, e_mdin});
    check("fill", {icache_data_wen, icache_tag_wen, dcache_data_wen, dcache_tag_wen,
                   fill_addr, fill_data}, {e_idw, e_itw, e_ddw, e_dtw, e_faddr, e_fdata});
    check("status", {icache_busy, dcache_busy, wr_done}, {e_ib, e_db, e_wd});

    if (icache_data_wen) cnt_iwen++;
    if (icache_tag_wen) cnt_itag++;
    if (dcache_data_wen) begin if (first_dwen < 0) first_dwen = cyc; cnt_dwen++; end
    if (dcache_tag_wen) begin cnt_dtag++; last_dtag = cyc; end
    if (dcache_busy) cnt_dbusy++;
    if (wr_done) cnt_wd++;
    if (icache_busy && !prev_ib) begin log_kind.push_back(1); log_addr.push_back(mem_addr); end
    if (dcache_busy && !prev_db) begin log_kind.push_back(2); log_addr.push_back(mem_addr); end
    prev_ib = icache_busy; prev_db = dcache_busy;

    if (!rst) begin
      m_kind = 0; m_owed_i = 0; m_cyc = 0; m_ret = 0; m_base = '0;
    end else if (m_kind == 0) begin
      if (g != 0) begin
        m_kind = g; m_cyc = 0; m_ret = 0;
        if (g == 1) m_base = icache_miss_addr & 16'hFFF0;
        if (g == 2) m_base = dcache_miss_addr & 16'hFFF0;
        m_owed_i = (g == 1) ? 0 : (m_owed_i || icache_miss);
      end
    end else if (m_kind == 3) m_kind = 0;
    else begin
      m_cyc++;
      if (mem_data_valid && m_ret < 8) m_ret++;
      if (m_ret == 8) m_kind = 0;
    end

    if (!rst) begin
      q_due.delete(); q_data.delete(); gap_left = 0;
    end else begin
      if (from_q) begin
        void'(q_due.pop_front()); void'(q_data.pop_front());
        mem_rets++;
        if (mem_rets == gap_at) gap_left = 2;
        else if (rand_gap && $urandom_range(0, 7) == 0) gap_left = $urandom_range(1, 3);
      end
      if (mem_enable && !mem_wr) begin
        q_due.push_back(cyc + lat); q_data.push_back(mem_arr[mem_addr[15:1]]);
      end
      if (mem_enable && mem_wr) mem_arr[mem_addr[15:1]] = mem_data_in;
    end

    if (e_itw) i_req = 0;
    if (e_dtw) begin
      d_req = 0;
      if (rearm_d) begin d_req = 1; d_addr = 16'h3000; rearm_d = 0; end
    end
    if (e_wd) w_req = 0;
    if (auto_req) begin
      if (!i_req && $urandom_range(0, 9) == 0) begin i_req = 1; i_addr = 16'($urandom); end
      if (!d_req && $urandom_range(0, 9) == 0) begin d_req = 1; d_addr = 16'($urandom); end
      if (!w_req && $urandom_range(0, 9) == 0) begin
        w_req = 1; w_addr = 16'($urandom); w_data = 16'($urandom);
      end
      // Address wiggles on a request already being served must not matter.
      if (m_kind == 1 && $urandom_range(0, 3) == 0) i_addr = 16'($urandom);
      if (m_kind == 2 && $urandom_range(0, 3) == 0) d_addr = 16'($urandom);
      rst_req = ($urandom_range(0, 399) != 0);
    end
    cyc++;
  endtask

  task automatic run_until_quiet(input string tag, input int budget);
    int n = 0;
    do begin step(); n++; end while ((i_req || d_req || w_req || m_kind != 0) && n < budget);
    check(tag, {i_req, d_req, w_req, m_kind != 0}, '0);
  endtask

  initial begin
    int t0, n;
    int          exp_kind [3] = '{2, 1, 2};
    logic [15:0] exp_addr [3] = '{16'h2000, 16'h0100, 16'h3000};
    for (int k = 0; k < 32768; k++) mem_arr[k] = 16'($urandom);
    clear_counts();

    // Reset with every request high.
    i_req = 1; i_addr = 16'h0700; d_req = 1; d_addr = 16'h0800;
    w_req = 1; w_addr = 16'h0900; w_data = 16'h1234;
    repeat (3) step();
    check("rst_quiet", {mem_enable, mem_wr, icache_busy, dcache_busy, wr_done,
                        icache_data_wen, dcache_data_wen, mem_addr}, '0);
    rst_req = 1;
    step();
    step();
    check("first_grant", dcache_busy, 1);
    run_until_quiet("rst_drain", 300);

    // D fill timing, latency 4.
    clear_counts();
    for (int k = 0; k < 8; k++) mem_arr[(16'h1230 >> 1) + k] = 16'hA000 + 16'(k);
    d_req = 1; d_addr = 16'h1236; t0 = cyc;
    run_until_quiet("dfill_done", 100);
    check("dfill_first_wen", 32'(first_dwen - t0), 5);
    check("dfill_tag_cycle", 32'(last_dtag - t0), 12);
    check("dfill_wen_count", cnt_dwen, 8);
    check("dfill_tag_count", cnt_dtag, 1);
    check("dfill_busy_cycles", cnt_dbusy, 12);

    // Store.
    clear_counts();
    w_req = 1; w_addr = 16'h0040; w_data = 16'hBEEF;
    run_until_quiet("store_done", 20);
    check("store_pulses", cnt_wd, 1);
    check("store_mem", mem_arr[16'h0020], 16'hBEEF);

    // Contention and fairness.
    clear_counts();
    i_req = 1; i_addr = 16'h0100; d_req = 1; d_addr = 16'h2000; rearm_d = 1;
    run_until_quiet("contend_done", 200);
    check("contend_count", log_kind.size(), 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("contend_order%0d", k),
            (k < log_kind.size()) ? {16'(log_kind[k]), log_addr[k]} : '0,
            {16'(exp_kind[k]), exp_addr[k]});

    // Wrap at the top block, latency 6, gap after word 3, then stray valids.
    clear_counts();
    lat = 6; mem_rets = 0; gap_at = 4;
    d_req = 1; d_addr = 16'hFFF8;
    run_until_quiet("wrap_done", 100);
    check("wrap_first_addr", (log_addr.size() > 0) ? log_addr[0] : 16'h0, 16'hFFF0);
    check("wrap_wen_count", cnt_dwen, 8);
    check("wrap_tag_count", cnt_dtag, 1);
    gap_at = -1; stray_en = 1;
    repeat (12) step();
    stray_en = 0;
    check("stray_no_wen", {cnt_dwen, cnt_iwen}, {32'd8, 32'd0});

    // Reset in the middle of an I fill.
    clear_counts();
    lat = 4; i_req = 1; i_addr = 16'h0500; n = 0;
    while (cnt_iwen < 3 && n < 50) begin step(); n++; end
    check("rstmid_reach", cnt_iwen, 3);
    rst_req = 0;
    step();
    check("rstmid_busy_drop", {icache_busy, icache_data_wen}, '0);
    step();
    rst_req = 1;
    check("rstmid_no_tag", cnt_itag, 0);
    cnt_iwen = 0;
    run_until_quiet("rstmid_refill", 100);
    check("rstmid_refill_wen", cnt_iwen, 8);
    check("rstmid_refill_tag", cnt_itag, 1);

    // Randomized traffic.
    for (int r = 0; r < 4; r++) begin
      lat = $urandom_range(1, 7); rand_gap = 1; stray_en = 1; auto_req = 1;
      repeat (500) step();
      auto_req = 0; rst_req = 1;
      run_until_quiet($sformatf("rand%0d_drain", r), 600);
      rand_gap = 0; stray_en = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
